shift_unit_seq: RTL

//   Iterative shifter that consumes the shift amount selected by the shamt-select mux and the operand path.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_step.sv | 26 ++
 rtl/shift_unit_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shifter: op encodings,
// FSM state enum and default widths.
package shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-bit-position shift step, purely combinational.
// Rotate-right on op 11 exists only when SHIFT_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  op_e              op,
    output logic [WIDTH-1:0] q
);

    // One position of SLL/SRL/SRA(/ROR); anything unlisted shifts left
    always_comb begin
        q = {d[WIDTH-2:0], 1'b0};
        case (op)
            OP_SRL: q = {1'b0, d[WIDTH-1:1]};
            OP_SRA: q = {d[WIDTH-1], d[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
            OP_ROR: q = {d[0], d[WIDTH-1:1]};
`endif
            default: q = {d[WIDTH-2:0], 1'b0};
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative shifter, one bit per clock, start/busy/done handshake.
// Optional rotate-right on op 11 via SHIFT_ROTATE_EN.
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [31:0]      shamt_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    state_e             state;
    state_e             state_n;
    logic [SHAMT_W-1:0] count;
    op_e                op_q;
    logic               load;
    logic               step_en;
    logic [WIDTH-1:0]   stepped;
    logic               shamt_unused;

    // Only the low shift-amount bits matter; the rest are dropped
    assign shamt_unused = ^shamt_in[31:SHAMT_W];

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .d  (data_out),
        .op (op_q),
        .q  (stepped)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step_en = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (shamt_in[SHAMT_W-1:0] == '0) state_n = S_DONE;
                    else                             state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy    = 1'b1;
                step_en = 1'b1;
                if (count == SHAMT_W'(1)) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Operand load, per-cycle step and remaining-count tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            count    <= '0;
            op_q     <= OP_SLL;
        end else if (load) begin
            data_out <= data_in;
            count    <= shamt_in[SHAMT_W-1:0];
            op_q     <= op_e'(op);
        end else if (step_en) begin
            data_out <= stepped;
            count    <= count - SHAMT_W'(1);
        end
    end

endmodule
